// File: rtl/pl_inv_iter.sv
// Iterative inverse of the ASCON linear diffusion layer pl.
// Every row map x ^ (x>>>a) ^ (x>>>b) has multiplicative order dividing 64,
// so applying the forward map 63 times yields its inverse. The block keeps
// one registered 320-bit state and applies UNROLL forward maps per clock
// until N_APPLY applications have been done.
`timescale 1ns/1ps

package ascon_pack;
    // Five 64-bit rows; row i (x_i) sits at index i.
    typedef logic [4:0][63:0] type_state;
endpackage

module pl_inv_iter #(
    parameter int UNROLL  = 1,
    parameter int N_APPLY = 63
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  ascon_pack::type_state state_i,
    output ascon_pack::type_state state_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // Rotation pair per row, identical to the forward diffusion layer.
    localparam int ROT_A [0:4] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [0:4] = '{28, 39, 6, 17, 41};

    // Counter step and terminal value in counter width (both fit in 6 bits).
    localparam logic [5:0] STEP     = 6'(UNROLL);
    localparam logic [5:0] TERMINAL = 6'(N_APPLY);

    // Reject parameter sets that cannot land exactly on the terminal count.
    generate
        if (!(UNROLL == 1 || UNROLL == 3 || UNROLL == 7 ||
              UNROLL == 9 || UNROLL == 21 || UNROLL == 63)) begin : g_bad_unroll
            $error("pl_inv_iter: UNROLL must divide 63 (1, 3, 7, 9, 21 or 63)");
        end
        if (N_APPLY < 1 || N_APPLY > 63 || (N_APPLY % UNROLL) != 0) begin : g_bad_n_apply
            $error("pl_inv_iter: N_APPLY must be a multiple of UNROLL in 1..63");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t                  fsm_reg;
    logic [5:0]            cnt_reg;
    logic [5:0]            cnt_next;
    ascon_pack::type_state state_reg;
    ascon_pack::type_state step_state;
    logic                  busy_reg;
    logic                  done_reg;

    // Per-row combinational chain: stage 0 is the register, stage gi+1 is
    // one forward application on top of stage gi.
    logic [63:0] chain [0:4][0:UNROLL];

    genvar gi;
    genvar ri;
    generate
        for (ri = 0; ri < 5; ri++) begin : g_row
            localparam int RA = ROT_A[ri];
            localparam int RB = ROT_B[ri];

            assign chain[ri][0] = state_reg[ri];

            for (gi = 0; gi < UNROLL; gi++) begin : g_stage
                logic [63:0] x;
                logic [63:0] ror_a;
                logic [63:0] ror_b;

                assign x     = chain[ri][gi];
                assign ror_a = {x[RA-1:0], x[63:RA]};
                assign ror_b = {x[RB-1:0], x[63:RB]};
                assign chain[ri][gi+1] = x ^ ror_a ^ ror_b;
            end
        end
    endgenerate

    // Gather the last stage of every row into the next register value.
    always_comb begin
        step_state = '0;
        for (int r = 0; r < 5; r++) begin
            step_state[r] = chain[r][UNROLL];
        end
    end

    // Terminal compare uses the counter value after this cycle's step.
    assign cnt_next = cnt_reg + STEP;

    // Control FSM with registered busy/done and the working state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_reg   <= IDLE;
            cnt_reg   <= 6'd0;
            state_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE, DONE: begin
                    // done is a single-cycle pulse; the result stays put
                    // until a new request overwrites it.
                    done_reg <= 1'b0;
                    if (start_i) begin
                        state_reg <= state_i;
                        cnt_reg   <= 6'd0;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= RUN;
                    end
                end
                RUN: begin
                    // Requests are ignored while iterating; no abort path.
                    state_reg <= step_state;
                    cnt_reg   <= cnt_next;
                    if (cnt_next == TERMINAL) begin
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        fsm_reg  <= DONE;
                    end
                end
                default: begin
                    fsm_reg  <= IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;

endmodule

// File: tb/tb_pl_inv_iter.sv
// Scoreboard bench for pl_inv_iter: four instances (inverse UNROLL=1, 7, 63
// and a forward single-application mode) share clock and reset. The driver
// pushes the expected result when it issues a request; a negedge monitor pops
// and compares whenever an instance raises done_o.
`timescale 1ns/1ps

module tb_pl_inv_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   start;
    logic [319:0] din  [4];
    logic [319:0] dout [4];
    logic [3:0]   busy;
    logic [3:0]   done;

    pl_inv_iter #(.UNROLL(1), .N_APPLY(63)) u_dut (
        .clock_i(clk), .reset_i(rst), .start_i(start[0]), .state_i(din[0]),
        .state_o(dout[0]), .busy_o(busy[0]), .done_o(done[0]));

    pl_inv_iter #(.UNROLL(7), .N_APPLY(63)) u_u7 (
        .clock_i(clk), .reset_i(rst), .start_i(start[1]), .state_i(din[1]),
        .state_o(dout[1]), .busy_o(busy[1]), .done_o(done[1]));

    pl_inv_iter #(.UNROLL(63), .N_APPLY(63)) u_u63 (
        .clock_i(clk), .reset_i(rst), .start_i(start[2]), .state_i(din[2]),
        .state_o(dout[2]), .busy_o(busy[2]), .done_o(done[2]));

    pl_inv_iter #(.UNROLL(1), .N_APPLY(1)) u_fwd (
        .clock_i(clk), .reset_i(rst), .start_i(start[3]), .state_i(din[3]),
        .state_o(dout[3]), .busy_o(busy[3]), .done_o(done[3]));

    typedef struct {
        int           id;
        logic [319:0] exp;
        bit           fwd_chk;
        int           lat;
    } sb_t;

    sb_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   busy_cnt [4] = '{0, 0, 0, 0};
    logic [319:0] zero_mask;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Golden forward diffusion layer.
    function automatic logic [319:0] gold_pl(input logic [319:0] s);
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        logic [319:0] res;
        logic [63:0]  x;
        res = '0;
        for (int r = 0; r < 5; r++) begin
            x = s[64*r +: 64];
            res[64*r +: 64] = x ^ rotr(x, ra[r]) ^ rotr(x, rb[r]);
        end
        return res;
    endfunction

    // Pack rows so that x_i lands at bits [64*i +: 64].
    function automatic logic [319:0] mk(input logic [63:0] x0, input logic [63:0] x1,
                                        input logic [63:0] x2, input logic [63:0] x3,
                                        input logic [63:0] x4);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] v;
        for (int w = 0; w < 10; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: pops one expectation per done pulse and measures busy length.
    always @(negedge clk) begin
        sb_t e;
        for (int k = 0; k < 4; k++) begin
            if (done[k]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("spurious_done%0d", k), 320'(done[k]), 320'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dut_id", 320'(k), 320'(e.id));
                    if (e.fwd_chk) begin
                        check("pl_of_result", gold_pl(dout[k]), e.exp);
                        check("zero_rows", dout[k] & zero_mask, 320'd0);
                    end else begin
                        check($sformatf("result%0d", k), dout[k], e.exp);
                    end
                    check($sformatf("latency%0d", k), 320'(busy_cnt[k]), 320'(e.lat));
                    check("busy_at_done", 320'(busy[k]), 320'd0);
                    $display("txn dut=%0d busy_cycles=%0d state=%h", k, busy_cnt[k], dout[k]);
                end
                busy_cnt[k] = 0;
            end else if (busy[k]) begin
                busy_cnt[k] = busy_cnt[k] + 1;
            end else begin
                busy_cnt[k] = 0;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            check("timeout", 320'(exp_q.size()), 320'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input int k, input logic [319:0] in_state,
                          input logic [319:0] exp, input bit fwd, input int lat);
        sb_t e;
        e.id = k; e.exp = exp; e.fwd_chk = fwd; e.lat = lat;
        @(negedge clk);
        exp_q.push_back(e);
        din[k]   = in_state;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        wait_drain(lat + 20);
    endtask

    logic [319:0] s_vec;
    logic [319:0] d_vec;
    logic [319:0] r_vec;
    logic [319:0] one_bit;
    sb_t          e5;
    int           n;

    initial begin
        zero_mask = ~({256'd0, 64'hFFFF_FFFF_FFFF_FFFF} << 128);
        rst   = 1'b1;
        start = 4'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_state", dout[0], 320'd0);
        check("rst_busy", 320'(busy), 320'd0);
        check("rst_done", 320'(done), 320'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        s_vec = mk(64'h25f7c341c45f9912, 64'h23b794c540876856, 64'hb85451593d679610,
                   64'h4fafba264a9e49ba, 64'h62b54d5d460aded4);
        d_vec = gold_pl(s_vec);

        // Round trip of the reference vector.
        run_op(0, d_vec, s_vec, 1'b0, 63);

        // Zero and all-ones are fixed points of every row map.
        run_op(0, 320'd0, 320'd0, 1'b0, 63);
        run_op(0, '1, '1, 1'b0, 63);

        // Random round trips.
        for (int i = 0; i < 3; i++) begin
            r_vec = rand_state();
            run_op(0, gold_pl(r_vec), r_vec, 1'b0, 63);
        end

        // Single set bit in row 2: forward map of the result restores input.
        one_bit = mk(64'h0, 64'h0, 64'h1, 64'h0, 64'h0);
        run_op(0, one_bit, one_bit, 1'b1, 63);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        din[0]   = d_vec;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", dout[0], 320'd0);
        check("async_rst_busy", 320'(busy[0]), 320'd0);
        check("async_rst_done", 320'(done[0]), 320'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        run_op(0, d_vec, s_vec, 1'b0, 63);

        // start held high: reloads happen only on the done cycle.
        e5.id = 0; e5.exp = s_vec; e5.fwd_chk = 1'b0; e5.lat = 63;
        @(negedge clk);
        for (int i = 0; i < 3; i++) exp_q.push_back(e5);
        din[0]   = d_vec;
        start[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done[0] && n < 80);
            if (!done[0]) check("hold_start_done", 320'(done[0]), 320'd1);
        end
        start[0] = 1'b0;
        wait_drain(10);
        repeat (80) @(negedge clk);

        // Parameter sweep.
        run_op(1, d_vec, s_vec, 1'b0, 9);
        run_op(2, d_vec, s_vec, 1'b0, 1);
        run_op(3, s_vec, d_vec, 1'b0, 1);
        r_vec = rand_state();
        run_op(3, r_vec, gold_pl(r_vec), 1'b0, 1);
        r_vec = rand_state();
        run_op(1, gold_pl(r_vec), r_vec, 1'b0, 9);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pl_inv_iter.md
Name: pl_inv_iter

Overview:
- Iterative inverse of the ASCON linear diffusion layer pl. It recovers the pre-diffusion state from a diffused state.
- It is used for decrypt-side permutation experiments and for self-checking pl in benches.
- The method relies on the fact that each row map is x ^ (x>>>a) ^ (x>>>b), a unit in GF(2)[X]/(X^64+1) with order dividing 64. Therefore L^-1 = L^63, so the block applies the forward pl map 63 times to a registered state.
- It uses type_state from ascon_pack and sits beside pl in the permutation datapath.

Parameters:
- UNROLL, 1, number of pl applications per clock. Legal values are 1, 3, 7, 9, 21 and 63, because the value must divide 63. Any other value is a compile-time error (elaboration assertion).
- N_APPLY, 63, total pl applications per operation. Keep 63 for the inverse. Setting it to UNROLL gives a forward-pl test mode. Must be a multiple of UNROLL.

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request pulse; state_i is sampled with it.
- state_i  input  type_state (5x64)  diffused state to invert.
- state_o  output  type_state (5x64)  working register and result.
- busy_o  output  1  high while iterating.
- done_o  output  1  one-cycle pulse when state_o holds the result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM goes to IDLE; iteration counter = 0.
  - state_o = 320'h0; busy_o = 0; done_o = 0.
  - The in-flight operation is discarded.
- Per-row rotations (ROR), applied identically to the forward pl:
  - x0: 19, 28
  - x1: 61, 39
  - x2: 1, 6
  - x3: 10, 17
  - x4: 7, 41
- Each application computes x_i' = x_i ^ ROR(x_i,a_i) ^ ROR(x_i,b_i) on all five rows in parallel. UNROLL applications are chained combinationally per cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 at a rising edge loads the register with state_i, sets counter = 0, moves to RUN, and sets busy_o = 1.
  - start_i=0: hold.
- RUN, each edge:
  - Register <= L^UNROLL(register); counter += UNROLL.
  - When the updated counter equals N_APPLY: go to DONE, busy_o = 0, done_o = 1 for exactly that following cycle.
  - start_i is ignored in RUN; there is no abort and no restart.
- DONE:
  - done_o returns to 0 after one cycle; state_o holds the result indefinitely.
  - start_i=1 reloads exactly as in IDLE (back-to-back operation). The result remains visible until that load edge.
- Latency: N_APPLY/UNROLL edges from the start edge to the edge that raises done_o. This is 63 cycles for UNROLL=1 and 1 cycle for UNROLL=63.
- Counter:
  - Width is 6 bits and it never wraps; the 63 terminal compare uses the updated value.
- The datapath is purely bitwise XOR/rotate: no carries, no width growth.
- start_i coinciding with the terminal RUN cycle is ignored. start_i coinciding with the done_o cycle (state DONE) is accepted.

Test Plan:
1. Round-trip, UNROLL=1: bench computes D = pl(S) with golden pl, where S = {25f7c341c45f9912, 23b794c540876856, b85451593d679610, 4fafba264a9e49ba, 62b54d5d460aded4}.
   - Pulse start_i with state_i = D.
   - Required: done_o exactly 63 cycles later, busy_o high for cycles 1..63, state_o == S.
2. Zero and all-ones:
   - state_i = 0 must give state_o = 0.
   - state_i = all-ones per row must give all-ones. Each row map has an odd number of terms, so all-ones is a fixed point.
3. Single-bit: x2 = 64'h1, other rows 0.
   - Required: pl(state_o) == input, and rows 0, 1, 3, 4 of state_o remain 0.
4. Reset mid-op: assert reset_i asynchronously 20 cycles after start.
   - Required: outputs go to 0 immediately, without waiting for a clock edge.
   - After release, no done_o is seen; a new start completes normally with the correct result.
5. start_i held high continuously:
   - Required: starts are ignored during RUN.
   - A reload happens on the done_o cycle, so done_o pulses every 64 cycles, each time with the correct result.
6. Parameter sweep:
   - UNROLL=7 gives latency 9; UNROLL=63 gives latency 1; both produce the same S as scenario 1.
   - N_APPLY=1 with UNROLL=1 gives state_o == pl(state_i) after 1 cycle.
